mips_pc_sequencer: RTL and testbench
====================================

Name: mips_pc_sequencer

Overview:
- Fetch/PC controller for the mips_cpu_harvard core. Owns the program counter and drives instr_address.
- Applies branch/jump redirects after exactly one delay-slot instruction.
- Halts the core when control transfers to HALT_ADDR and drives the active flag.
- Sits between the decode/branch-resolution logic and the instruction-memory address port.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, fetch address that terminates execution.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset.
- clk_enable  input  1  global advance enable; low freezes all state.
- stall  input  1  datapath hazard/memory wait; high holds the PC for this cycle.
- branch_taken  input  1  resolved conditional branch for the instruction at instr_address.
- branch_target  input  32  branch destination.
- jump  input  1  unconditional jump (j/jal/jr/jalr) for the instruction at instr_address.
- jump_target  input  32  jump destination.
- instr_address  output  32  current fetch PC.
- in_delay_slot  output  1  current instruction is a delay slot.
- active  output  1  core running; 0 once halted.
- misaligned  output  1  one-cycle pulse: a redirect target had nonzero bits [1:0].

Behaviour:
- State is RUN, DELAY or HALT; pending_target is a 32-bit register.
- Reset (reset==0 at posedge): instr_address=RESET_VECTOR, state=RUN, pending_target=0, in_delay_slot=0, active=1, misaligned=0. Reset overrides clk_enable and stall and applies in any state, including DELAY.
- A cycle "advances" only if clk_enable=1, stall=0 and state!=HALT. Otherwise every register holds and misaligned=0.
- RUN, no redirect: instr_address <= instr_address+4, modulo 2^32.
- RUN, branch_taken or jump:
  - instr_address <= instr_address+4 (the delay slot).
  - pending_target <= selected target with bits[1:0] forced to 00.
  - state <= DELAY, in_delay_slot <= 1.
- Target select: jump has priority over branch_taken when both are high.
- misaligned pulses for one advancing cycle when the selected target has bits[1:0]!=0.
- DELAY, advancing: instr_address <= pending_target, state <= RUN, in_delay_slot <= 0.
- A redirect asserted during DELAY is ignored: a branch inside a delay slot is unsupported, and no pending target is overwritten.
- Halt: when an advance would load HALT_ADDR into instr_address (redirect or sequential wrap):
  - instr_address <= HALT_ADDR, active <= 0, state <= HALT.
  - HALT is sticky until reset; inputs are ignored.
- Latency: a redirect decided on instruction N takes effect at fetch N+2, i.e. two advancing cycles after N is fetched.
- Stall or clk_enable low in DELAY keeps pending_target and in_delay_slot unchanged.
- Width rules: all PC arithmetic is unsigned 32-bit; carry-out is discarded.

Decomposition:
- mips_pkg holds:
  - the pc_state_t enum {RUN, DELAY, HALT};
  - constants RESET_VECTOR_DEFAULT and HALT_ADDR_DEFAULT;
  - the PC_INC=4 constant.
- No sub-module: next-PC mux plus FSM in a single module.
- The core instantiates it in place of its inline PC register.

Test Plan:
- Taken blez at BFC00000, target BFC0000C, no stalls -> instr_address sequence BFC00000, BFC00004 (in_delay_slot=1), BFC0000C, BFC00010; active stays 1.
- Non-taken branch for 3 cycles -> BFC00000, BFC00004, BFC00008, BFC0000C; in_delay_slot always 0.
- jr to 0 at BFC00010 -> BFC00014 delay slot, then instr_address=0, active=0. Further jump/branch inputs leave instr_address=0 and active=0 for 10 cycles.
- Branch at BFC00000 to BFC00020 with stall=1 on the delay cycle for 3 cycles -> instr_address holds BFC00004 for 3 cycles, then goes to BFC00020.
- Branch and jump both high at BFC00000 (branch_target BFC00100, jump_target BFC00201) -> delay slot BFC00004, then BFC00200; misaligned pulses once.
- reset driven low while in DELAY -> next posedge instr_address=BFC00000, in_delay_slot=0, active=1; the pending target is never fetched.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the mips_cpu_harvard fetch
//                path: PC sequencer state encoding, reset/halt addresses,
//                the sequential PC increment and a target-alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // PC sequencer state: normal fetch, one delay slot pending, or stopped.
    typedef enum logic [1:0] {
        PC_RUN   = 2'b00,
        PC_DELAY = 2'b01,
        PC_HALT  = 2'b10
    } pc_state_t;

    // Boot ROM entry point of the MIPS kseg1 reset vector.
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    // Control transfer to this address stops the core.
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

    // Sequential fetch step in bytes (one 32-bit instruction word).
    localparam logic [31:0] PC_INC               = 32'd4;

    // Word-align a redirect destination; the low two bits are dropped so the
    // fetch port only ever sees word addresses.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pc_sequencer
//  Description : Program counter and fetch controller for mips_cpu_harvard.
//                Drives instr_address, applies branch/jump redirects after
//                exactly one delay-slot instruction and halts the core when
//                control reaches HALT_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,          // synchronous, active-low
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_address,
    output logic        in_delay_slot,
    output logic        active,
    output logic        misaligned
);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    pc_state_t   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending_target;
    logic        r_in_delay_slot;
    logic        r_active;
    logic        r_misaligned;

    // ------------------------------------------------------------------------
    // Next-PC datapath
    // ------------------------------------------------------------------------
    logic        w_advance;
    logic        w_redirect;
    logic [31:0] w_sel_target;
    logic [31:0] w_seq_pc;
    logic        w_seq_halts;
    logic        w_pending_halts;

    // Advance qualification, redirect target selection and halt detection.
    always_comb begin
        w_advance       = clk_enable && !stall && (r_state != PC_HALT);
        w_redirect      = jump || branch_taken;
        // Jump wins when the decoder reports both in the same cycle.
        w_sel_target    = jump ? jump_target : branch_target;
        // Carry-out of the increment is intentionally discarded (mod 2^32).
        w_seq_pc        = r_pc + PC_INC;
        w_seq_halts     = (w_seq_pc == HALT_ADDR);
        w_pending_halts = (r_pending_target == HALT_ADDR);
    end

    // ------------------------------------------------------------------------
    // PC register and sequencing FSM
    // ------------------------------------------------------------------------

    // Reset has absolute priority; otherwise registers move only on advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= PC_RUN;
            r_pc             <= RESET_VECTOR;
            r_pending_target <= 32'd0;
            r_in_delay_slot  <= 1'b0;
            r_active         <= 1'b1;
            r_misaligned     <= 1'b0;
        end else begin
            // misaligned is a single-cycle pulse; default it low every cycle.
            r_misaligned <= 1'b0;
            if (w_advance) begin
                case (r_state)
                    PC_RUN: begin
                        // Flag a bad redirect even if the delay slot itself
                        // happens to land on the halt address.
                        if (w_redirect) begin
                            r_misaligned <= |w_sel_target[1:0];
                        end
                        if (w_seq_halts) begin
                            r_pc            <= HALT_ADDR;
                            r_state         <= PC_HALT;
                            r_active        <= 1'b0;
                            r_in_delay_slot <= 1'b0;
                        end else begin
                            // The delay slot is always the next sequential word.
                            r_pc <= w_seq_pc;
                            if (w_redirect) begin
                                r_pending_target <= align_target(w_sel_target);
                                r_state          <= PC_DELAY;
                                r_in_delay_slot  <= 1'b1;
                            end
                        end
                    end
                    PC_DELAY: begin
                        // Any redirect seen here belongs to a delay-slot
                        // instruction and is dropped; the saved target wins.
                        r_pc            <= r_pending_target;
                        r_in_delay_slot <= 1'b0;
                        if (w_pending_halts) begin
                            r_state  <= PC_HALT;
                            r_active <= 1'b0;
                        end else begin
                            r_state  <= PC_RUN;
                        end
                    end
                    default: begin
                        // PC_HALT never advances; w_advance excludes it.
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign instr_address = r_pc;
    assign in_delay_slot = r_in_delay_slot;
    assign active        = r_active;
    assign misaligned    = r_misaligned;

endmodule : mips_pc_sequencer
`default_nettype wire

// File: tb/tb_mips_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_pc_sequencer
//  Description : Self-checking bench for mips_pc_sequencer. Directed
//                scenarios followed by randomized traffic, compared every
//                cycle against a behavioural fetch model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_pc_sequencer;

    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] HA = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr_address;
    logic        in_delay_slot;
    logic        active;
    logic        misaligned;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: the PC, a queue of redirect targets still owed
    // (at most one entry, meaning "a delay slot is being fetched"),
    // a halted flag and the misaligned pulse.
    logic [31:0] m_pc;
    logic [31:0] m_owed[$];
    bit          m_halted;
    bit          m_mis;

    mips_pc_sequencer #(
        .RESET_VECTOR (RV),
        .HALT_ADDR    (HA)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .instr_address (instr_address),
        .in_delay_slot (in_delay_slot),
        .active        (active),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the fetch rules as written for the core.
    task automatic model_step(input bit rn, input bit ce, input bit st,
                              input bit bt, input logic [31:0] btg,
                              input bit j, input logic [31:0] jtg);
        logic [31:0] sel;
        logic [31:0] nxt;
        if (!rn) begin
            m_pc = RV; m_owed.delete(); m_halted = 0; m_mis = 0;
        end else if (!ce || st || m_halted) begin
            m_mis = 0;
        end else if (m_owed.size() == 0) begin
            sel   = j ? jtg : btg;
            nxt   = m_pc + 32'd4;
            m_mis = (j || bt) && (sel % 4 != 0);
            if (nxt == HA) begin
                m_pc = HA; m_halted = 1;
            end else begin
                m_pc = nxt;
                if (j || bt) m_owed.push_back(sel - (sel % 4));
            end
        end else begin
            m_pc  = m_owed.pop_front();
            m_mis = 0;
            if (m_pc == HA) m_halted = 1;
        end
    endtask

    // Apply inputs, clock once, update the model, compare all outputs.
    task automatic cyc(input bit rn, input bit ce, input bit st,
                       input bit bt, input logic [31:0] btg,
                       input bit j, input logic [31:0] jtg);
        reset = rn; clk_enable = ce; stall = st;
        branch_taken = bt; branch_target = btg;
        jump = j; jump_target = jtg;
        @(posedge clk);
        model_step(rn, ce, st, bt, btg, j, jtg);
        #1;
        check_eq("instr_address", instr_address, m_pc);
        check_eq("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, m_owed.size() != 0});
        check_eq("active",        {31'd0, active},        {31'd0, !m_halted});
        check_eq("misaligned",    {31'd0, misaligned},    {31'd0, m_mis});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic do_reset();
        cyc(0, 1, 0, 0, 32'd0, 0, 32'd0);
    endtask

    int mis_count;

    initial begin
        reset = 0; clk_enable = 1; stall = 0;
        branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
        m_pc = RV; m_halted = 0; m_mis = 0;

        // Reset state, with enable low and stall high to show reset wins.
        reset = 0; clk_enable = 0; stall = 1;
        @(posedge clk);
        model_step(0, 0, 1, 0, 0, 0, 0);
        #1;
        check_eq("rst_pc",     instr_address, 32'hBFC0_0000);
        check_eq("rst_ds",     {31'd0, in_delay_slot}, 32'd0);
        check_eq("rst_active", {31'd0, active}, 32'd1);
        check_eq("rst_mis",    {31'd0, misaligned}, 32'd0);

        // Taken branch at BFC00000 to BFC0000C.
        cyc(1, 1, 0, 1, 32'hBFC0_000C, 0, 32'd0);
        check_eq("br_slot_pc", instr_address, 32'hBFC0_0004);
        check_eq("br_slot_ds", {31'd0, in_delay_slot}, 32'd1);
        idle(1);
        check_eq("br_tgt_pc", instr_address, 32'hBFC0_000C);
        idle(1);
        check_eq("br_seq_pc", instr_address, 32'hBFC0_0010);
        check_eq("br_active", {31'd0, active}, 32'd1);

        // Not-taken branches: plain sequential fetch.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 1, 0, 0, 32'hBFC0_0040, 0, 32'd0);
            check_eq("nt_pc", instr_address, RV + 32'(4 * i));
        end

        // jr to 0 at BFC00010 halts after the delay slot.
        do_reset();
        idle(4);
        check_eq("jr_pc", instr_address, 32'hBFC0_0010);
        cyc(1, 1, 0, 0, 32'd0, 1, 32'd0);
        check_eq("jr_slot", instr_address, 32'hBFC0_0014);
        idle(1);
        check_eq("halt_pc",     instr_address, 32'd0);
        check_eq("halt_active", {31'd0, active}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0200);
            check_eq("halt_sticky_pc", instr_address, 32'd0);
        end

        // Stall during the delay slot holds the slot address.
        do_reset();
        cyc(1, 1, 0, 1, 32'hBFC0_0020, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 1, 32'hBFC0_0400, 1, 32'hBFC0_0500);
            check_eq("stall_pc", instr_address, 32'hBFC0_0004);
        end
        idle(1);
        check_eq("stall_tgt", instr_address, 32'hBFC0_0020);

        // Branch and jump together: jump wins, target gets aligned.
        do_reset();
        mis_count = 0;
        cyc(1, 1, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0201);
        check_eq("pri_slot", instr_address, 32'hBFC0_0004);
        if (misaligned) mis_count++;
        idle(1);
        check_eq("pri_tgt", instr_address, 32'hBFC0_0200);
        if (misaligned) mis_count++;
        idle(1);
        if (misaligned) mis_count++;
        check_eq("mis_pulses", mis_count, 1);

        // Reset while a delay slot is pending discards the target.
        cyc(1, 1, 0, 0, 32'd0, 1, 32'hBFC0_0800);
        check_eq("pre_rst_ds", {31'd0, in_delay_slot}, 32'd1);
        do_reset();
        check_eq("rd_pc", instr_address, 32'hBFC0_0000);
        check_eq("rd_ds", {31'd0, in_delay_slot}, 32'd0);
        idle(2);
        check_eq("rd_seq", instr_address, 32'hBFC0_0008);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit          rn, ce, st, bt, j;
            logic [31:0] btg, jtg;
            rn  = ($urandom_range(0, 39) != 0);
            ce  = ($urandom_range(0, 7) != 0);
            st  = ($urandom_range(0, 4) == 0);
            bt  = ($urandom_range(0, 5) == 0);
            j   = ($urandom_range(0, 9) == 0);
            btg = 32'hBFC0_0000 | ($urandom & 32'h0000_FFFF);
            jtg = ($urandom_range(0, 24) == 0) ? ($urandom & 32'h3)
                                               : (32'hBFC0_0000 | ($urandom & 32'h0000_FFFF));
            cyc(rn, ce, st, bt, btg, j, jtg);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mips_pc_sequencer
`default_nettype wire
